// File: rtl/rf_result_checker.sv
// Run monitor: snoops register-file write-back and PC, detects program end
// (halt self-loop or timeout), then checks a programmable expectation table.
module rf_result_checker #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HALT_CYCLES    = 3,
  localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rf_we,
  input  logic [REG_ADDR_W-1:0] rf_waddr,
  input  logic [XLEN-1:0]       rf_wdata,
  input  logic [XLEN-1:0]       pc,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [REG_ADDR_W-1:0] cfg_addr,
  input  logic [XLEN-1:0]       cfg_data,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic                  fail_valid,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [XLEN-1:0]       fail_actual,
  output logic [31:0]           run_cycles
);

  localparam int SAME_W = $clog2(HALT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {ST_RUN, ST_CHECK, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [NUM_CHECKS-1:0]   slot_valid_q, slot_valid_d;
  logic [NUM_CHECKS-1:0]   slot_seen_q, slot_seen_d;
  logic [REG_ADDR_W-1:0]   slot_addr_q [NUM_CHECKS];
  logic [REG_ADDR_W-1:0]   slot_addr_d [NUM_CHECKS];
  logic [XLEN-1:0]         slot_exp_q  [NUM_CHECKS];
  logic [XLEN-1:0]         slot_exp_d  [NUM_CHECKS];
  logic [XLEN-1:0]         slot_val_q  [NUM_CHECKS];
  logic [XLEN-1:0]         slot_val_d  [NUM_CHECKS];

  logic [XLEN-1:0]         pc_prev_q, pc_prev_d;
  logic                    pc_prev_valid_q, pc_prev_valid_d;
  logic [SAME_W-1:0]       same_cnt_q, same_cnt_d;
  logic [31:0]             run_cycles_q, run_cycles_d;

  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    timed_out_q, timed_out_d;
  logic                    fail_valid_q, fail_valid_d;
  logic [IDX_W-1:0]        fail_idx_q, fail_idx_d;
  logic [XLEN-1:0]         fail_actual_q, fail_actual_d;

  logic                    halt_hit;
  logic                    tmo_hit;
  logic                    cfg_in_range;
  logic                    cur_seen;
  logic [XLEN-1:0]         cur_value;
  logic                    cur_mismatch;

  assign halt_hit     = (same_cnt_q == SAME_W'(HALT_CYCLES));
  assign tmo_hit      = (run_cycles_q == 32'(TIMEOUT_CYCLES - 1));
  assign cfg_in_range = (32'(cfg_idx) < 32'(NUM_CHECKS));

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    slot_valid_d    = slot_valid_q;
    slot_seen_d     = slot_seen_q;
    slot_addr_d     = slot_addr_q;
    slot_exp_d      = slot_exp_q;
    slot_val_d      = slot_val_q;
    pc_prev_d       = pc_prev_q;
    pc_prev_valid_d = pc_prev_valid_q;
    same_cnt_d      = same_cnt_q;
    run_cycles_d    = run_cycles_q;
    done_d          = done_q;
    pass_d          = pass_q;
    timed_out_d     = timed_out_q;
    fail_valid_d    = fail_valid_q;
    fail_idx_d      = fail_idx_q;
    fail_actual_d   = fail_actual_q;
    cur_seen        = 1'b0;
    cur_value       = '0;
    cur_mismatch    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end

        pc_prev_d       = pc;
        pc_prev_valid_d = 1'b1;
        if (pc_prev_valid_q && (pc == pc_prev_q)) begin
          same_cnt_d = same_cnt_q + SAME_W'(1);
        end else begin
          same_cnt_d = '0;
        end

        // Programming clears the shadow first so a same-cycle matching write-back wins.
        for (int i = 0; i < NUM_CHECKS; i++) begin
          if (cfg_we && cfg_in_range && (cfg_idx == IDX_W'(i))) begin
            slot_valid_d[i] = 1'b1;
            slot_addr_d[i]  = cfg_addr;
            slot_exp_d[i]   = cfg_data;
            slot_seen_d[i]  = 1'b0;
            slot_val_d[i]   = '0;
          end
          if (rf_we && (rf_waddr != '0) && slot_valid_d[i] &&
              (slot_addr_d[i] == rf_waddr)) begin
            slot_seen_d[i] = 1'b1;
            slot_val_d[i]  = rf_wdata;
          end
        end

        if (halt_hit || tmo_hit) begin
          state_d     = ST_CHECK;
          idx_d       = '0;
          timed_out_d = !halt_hit;
        end
      end

      ST_CHECK: begin
        cur_seen     = slot_seen_q[idx_q] || (slot_addr_q[idx_q] == '0);
        cur_value    = slot_seen_q[idx_q] ? slot_val_q[idx_q] : '0;
        cur_mismatch = slot_valid_q[idx_q] &&
                       (!cur_seen || (cur_value != slot_exp_q[idx_q]));

        if (cur_mismatch && !fail_valid_q) begin
          fail_valid_d  = 1'b1;
          fail_idx_d    = idx_q;
          fail_actual_d = cur_value;
        end

        if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = !timed_out_q && !fail_valid_d;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      idx_q           <= '0;
      slot_valid_q    <= '0;
      slot_seen_q     <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        slot_addr_q[i] <= '0;
        slot_exp_q[i]  <= '0;
        slot_val_q[i]  <= '0;
      end
      pc_prev_q       <= '0;
      pc_prev_valid_q <= 1'b0;
      same_cnt_q      <= '0;
      run_cycles_q    <= '0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      timed_out_q     <= 1'b0;
      fail_valid_q    <= 1'b0;
      fail_idx_q      <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      slot_valid_q    <= slot_valid_d;
      slot_seen_q     <= slot_seen_d;
      slot_addr_q     <= slot_addr_d;
      slot_exp_q      <= slot_exp_d;
      slot_val_q      <= slot_val_d;
      pc_prev_q       <= pc_prev_d;
      pc_prev_valid_q <= pc_prev_valid_d;
      same_cnt_q      <= same_cnt_d;
      run_cycles_q    <= run_cycles_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      timed_out_q     <= timed_out_d;
      fail_valid_q    <= fail_valid_d;
      fail_idx_q      <= fail_idx_d;
      fail_actual_q   <= fail_actual_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_valid  = fail_valid_q;
  assign fail_idx    = fail_idx_q;
  assign fail_actual = fail_actual_q;
  assign run_cycles  = run_cycles_q;

endmodule

// File: doc/rf_result_checker.md
# rf_result_checker

Synthesizable run-monitor and self-check engine that sits beside the `processor` core in simulation and FPGA bring-up builds. It snoops the register-file write-back port and the PC, and holds a programmable table of expected (register, value) pairs. It detects program end, either a halt self-loop or a cycle timeout, and then sequentially checks every table entry. It reports done/pass plus the first failing entry, replacing fixed-delay `$display` inspection with a parametrised, cycle-exact verdict.

## Interface
- `XLEN`, 32, data and PC width
- `REG_ADDR_W`, 5, register address width
- `NUM_CHECKS`, 4, expectation table depth (≥1); `IDX_W = max(1,$clog2(NUM_CHECKS))`
- `TIMEOUT_CYCLES`, 1000, RUN cycles before forced end (≥1)
- `HALT_CYCLES`, 3, consecutive cycles of unchanged PC that mean halt (≥1)

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `rf_we` in 1: register-file write enable (snooped)
- `rf_waddr` in REG_ADDR_W: write address
- `rf_wdata` in XLEN: write data
- `pc` in XLEN: current PC
- `cfg_we` in 1: expectation-table write strobe
- `cfg_idx` in IDX_W: table slot
- `cfg_addr` in REG_ADDR_W: expected register
- `cfg_data` in XLEN: expected value
- `done` out 1: verdict valid, sticky until `rst`
- `pass` out 1: no timeout and no mismatch; valid only with `done`
- `timed_out` out 1: run ended by timeout
- `fail_valid` out 1: at least one mismatch found
- `fail_idx` out IDX_W: slot of first mismatch
- `fail_actual` out XLEN: observed value for `fail_idx`
- `run_cycles` out 32: RUN cycles elapsed, saturating at all-ones

## Operation
- States: RUN, CHECK, DONE. Reset enters RUN.
- Reset clears all slot valid/seen bits, shadows, counters, and all outputs (all 0).
- RUN: `run_cycles` increments each cycle.
- RUN, `cfg_we`: slot `cfg_idx` ← {valid=1, addr, data}, and its shadow is cleared (seen=0, value=0). Out-of-range `cfg_idx` is ignored.
- RUN, `rf_we` with `rf_waddr`≠0: every valid slot whose addr matches captures seen=1, value=`rf_wdata`. The last write wins.
- Writes to x0 are never captured. A slot with addr 0 is treated as seen with value 0.
- Same cycle as `cfg_we`: an `rf_we` matching the new `cfg_addr` is captured into that slot. Capture has priority over the clear.
- Halt detect: `pc_prev` is registered with a valid flag (invalid after reset).
  - `same_cnt` increments when `pc_prev` is valid and `pc==pc_prev`; otherwise it resets to 0.
  - `same_cnt==HALT_CYCLES` → end of run.
- Timeout: `run_cycles==TIMEOUT_CYCLES-1` with no halt → set `timed_out`, end of run. Halt and timeout in the same cycle counts as halt (`timed_out`=0).
- End of run → CHECK with idx=0. Write-back and cfg activity on the end cycle is still processed; after that both are ignored.
- CHECK: one slot per cycle, idx 0..NUM_CHECKS-1.
  - A slot mismatches if valid and (!seen or value≠expected).
  - On the first mismatch, latch `fail_valid`=1, `fail_idx`=idx, `fail_actual`=shadow value (0 if unseen). Later mismatches are ignored.
  - Invalid slots are skipped but still take one cycle.
- After the last idx → DONE: `done`=1, `pass`=!`timed_out` && !`fail_valid`. All outputs hold until `rst`.
- An empty table passes, unless timed out.
- `rst` in any state, including mid-CHECK, aborts and returns to the reset state next cycle.

## Timing
- All outputs are registered. No combinational input→output path.
- Halt is recognised HALT_CYCLES+1 cycles after the PC first repeats a value. Example: pc A then A,A,A with HALT_CYCLES=3 → end on the cycle the third repeat is sampled.
- End-of-run cycle E: CHECK occupies cycles E+1..E+NUM_CHECKS. `done` rises at E+NUM_CHECKS+1.
- Timeout: E = cycle TIMEOUT_CYCLES-1 after reset release. `done` rises TIMEOUT_CYCLES+NUM_CHECKS cycles after release.
- `run_cycles` freezes at E+1.

## Test plan
- Slot0={x2,0x0000000A}. Write x2=5, then x2=0xA. PC holds at 0x40 for 4 cycles → `done`=1, `pass`=1, `timed_out`=0, `done` at E+5.
- Slot1={x9,0x3}, x9 written 0x6 → `fail_valid`=1, `fail_idx`=1, `fail_actual`=0x6, `pass`=0.
- Slot2={x7,0x12345678}, x7 never written → `fail_idx`=2, `fail_actual`=0.
- TIMEOUT_CYCLES=20, PC increments by 4 forever, slots match → `timed_out`=1, `pass`=0, `run_cycles`=20, `done` at cycle 24 after release.
- Same-cycle `cfg_we` slot0={x10,0xFF} and `rf_we` x10=0xFF; also a write to x0=0x55 with slot3={x0,0} → `pass`=1.
- Assert `rst` during CHECK, then run a passing program → no stale `fail_*` or `done`, and a clean pass.
